amp_pwr_seq: RTL and testbench
==============================

// Module: amp_pwr_seq
// PURPOSE
//  Power-up / fault sequencer for the class-D amplifier stage. Holds sht_dwn high
//  until the EQ queues report full (seq_low), then releases the amp after a settle delay.
//  Unmutes the PDM driver on a sample (vld) boundary.
//  On an amp fault (Flt_n low) it shuts down, waits for a clean recovery interval, then
//  re-sequences. Sits in Equalizer top between EQ_engine/spkr_drv and the sht_dwn pin.
// PARAMETERS
//  STARTUP_CYC   250000  clk cycles sht_dwn stays high after seq_low before amp enable
//  FLT_HOLD_CYC  2500000 clk cycles Flt_n must stay high continuously before re-arm
//  RETRY_MAX     3       faults tolerated before lockout (RETRY_LIMIT_EN only)
// PORTS
//  clk        in   1   50MHz system clock
//  rst_n      in   1   active-low reset, synchronous to clk
//  Flt_n      in   1   amp fault, active low, asynchronous (synchronized internally)
//  seq_low    in   1   EQ_engine low-freq queues full
//  vld        in   1   1-clk new-sample strobe from I2S_Serf
//  sht_dwn    out  1   amp shutdown, 1 = amp off
//  mute       out  1   1 = spkr_drv forces zero/mid-scale output
//  amp_on     out  1   1 in RUN state only
//  fault_cnt  out  4   faults since reset, saturates at 15
//  locked     out  1   1 = LOCKOUT (always 0 without RETRY_LIMIT_EN)
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low: clk, rst_n. All logic on posedge clk.
//    All outputs registered.
//  - Reset values: sht_dwn=1, mute=1, amp_on=0, fault_cnt=0, locked=0, state=IDLE, timer=0.
//  - Flt_n passes through 2 flops (reset value 1); flt = ~synced value.
//  - Single timer, width $clog2(max(STARTUP_CYC,FLT_HOLD_CYC))+1; cleared on every state entry.
//  - States:
//    IDLE:   sht_dwn=1, mute=1; seq_low=1 -> WARM.
//    WARM:   sht_dwn=1, mute=1; timer counts.
//            Timer reaches STARTUP_CYC-1 -> UNMUTE.
//    UNMUTE: sht_dwn=0, mute=1; next vld -> RUN.
//    RUN:    sht_dwn=0, mute=0, amp_on=1; seq_low ignored.
//    FAULT:  sht_dwn=1, mute=1; timer counts only while flt=0, cleared whenever flt=1.
//            Timer reaches FLT_HOLD_CYC-1 -> IDLE; seq_low is re-checked there.
//  - Fault entry: flt=1 in WARM, UNMUTE or RUN -> FAULT. fault_cnt increments (saturating).
//  - Fault latency: Flt_n low at edge N => sht_dwn=1 and mute=1 visible after edge N+3
//    (2 sync + 1 output register).
//  - Exactly one fault_cnt increment per FAULT entry, regardless of Flt_n pulse length.
//  - Fault is not counted in IDLE or FAULT; flt in IDLE only blocks WARM entry.
//  - Simultaneous events:
//    flt and vld in UNMUTE -> FAULT wins.
//    flt and timer terminal count in WARM -> FAULT wins.
//  - Flt_n glitch of 1 cycle in FAULT restarts the full FLT_HOLD_CYC interval.
//  - rst_n low mid-sequence: next edge returns all registers to reset values.
//    fault_cnt and lockout are cleared.
// CONFIGURATION
//  - RETRY_LIMIT_EN defined:
//    on FAULT entry with fault_cnt (post-increment) >= RETRY_MAX -> LOCKOUT instead of FAULT.
//    LOCKOUT: sht_dwn=1, mute=1, locked=1; exits only via rst_n.
//  - RETRY_LIMIT_EN undefined: no LOCKOUT state, locked tied 0, retries indefinitely.
// TESTING (bench params STARTUP_CYC=16, FLT_HOLD_CYC=8, RETRY_MAX=2)
//  - Reset, seq_low=1 at cycle 0 -> sht_dwn falls after 16 WARM cycles.
//    mute falls the cycle after first subsequent vld; amp_on=1.
//  - RUN, Flt_n low 1 cycle -> sht_dwn=1, mute=1 3 edges later; fault_cnt=1.
//    After 8 clean cycles -> IDLE -> WARM.
//  - FAULT, Flt_n pulses low at hold count 5 -> timer restarts; IDLE reached only
//    8 cycles after last low.
//  - UNMUTE, flt and vld same cycle -> FAULT, mute stays 1, fault_cnt increments.
//  - RETRY_LIMIT_EN: 2nd fault -> locked=1, sht_dwn=1 held 100 cycles with Flt_n high.
//    rst_n low 1 cycle -> locked=0, fault_cnt=0. Without macro: 2nd fault re-sequences.
//  - rst_n asserted mid-WARM (timer=9) -> next edge sht_dwn=1, timer=0, state IDLE.

Source files
------------

// File: rtl/amp_pwr_seq.sv
// Class-D amplifier power-up / fault sequencer: gates sht_dwn and mute.
// Optional retry lockout is enabled by defining RETRY_LIMIT_EN.
module amp_pwr_seq #(
    parameter int STARTUP_CYC  = 250000,
    parameter int FLT_HOLD_CYC = 2500000,
    parameter int RETRY_MAX    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Flt_n,
    input  logic       seq_low,
    input  logic       vld,
    output logic       sht_dwn,
    output logic       mute,
    output logic       amp_on,
    output logic [3:0] fault_cnt,
    output logic       locked
);

    localparam int MAX_CYC = (STARTUP_CYC > FLT_HOLD_CYC) ?
                             STARTUP_CYC : FLT_HOLD_CYC;
    localparam int TW = $clog2(MAX_CYC) + 1;

    localparam logic [TW-1:0] WARM_END = TW'(STARTUP_CYC - 1);
    localparam logic [TW-1:0] HOLD_END = TW'(FLT_HOLD_CYC - 1);

`ifdef RETRY_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARM,
        S_UNMUTE,
        S_RUN,
        S_FAULT,
        S_LOCK
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic [3:0]      r_fault_cnt;
    logic            r_flt_s1;
    logic            r_flt_s2;
    // {sht_dwn, mute, amp_on, locked}
    logic [3:0]      r_out;

    logic            w_flt;
    logic            w_armed;
    logic [3:0]      w_cnt_inc;
    logic            w_lock_hit;
    state_t          w_flt_st;

    // Output pattern for each state, loaded together with the state.
    function automatic logic [3:0] f_out(state_t s);
        logic [3:0] v;
        v = 4'b1100;
        case (s)
            S_UNMUTE: v = 4'b0100;
            S_RUN:    v = 4'b0010;
`ifdef RETRY_LIMIT_EN
            S_LOCK:   v = 4'b1101;
`endif
            default:  v = 4'b1100;
        endcase
        return v;
    endfunction

    assign w_flt     = ~r_flt_s2;
    assign w_armed   = (r_state == S_WARM) ||
                       (r_state == S_UNMUTE) ||
                       (r_state == S_RUN);
    assign w_cnt_inc = (r_fault_cnt == 4'hF) ? 4'hF :
                       r_fault_cnt + 4'd1;
    assign w_lock_hit = LIMIT_EN &&
                        (int'(w_cnt_inc) >= RETRY_MAX);
    assign w_flt_st  = w_lock_hit ? S_LOCK : S_FAULT;

    // Two-flop synchronizer for the asynchronous fault pin, idles high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_flt_s1 <= 1'b1;
            r_flt_s2 <= 1'b1;
        end else begin
            r_flt_s1 <= Flt_n;
            r_flt_s2 <= r_flt_s1;
        end
    end

    // Sequencer FSM: state, shared timer, fault counter and outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_fault_cnt <= '0;
            r_out       <= 4'b1100;
        end else if (w_flt && w_armed) begin
            r_state     <= w_flt_st;
            r_timer     <= '0;
            r_fault_cnt <= w_cnt_inc;
            r_out       <= f_out(w_flt_st);
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (seq_low && !w_flt) begin
                        r_state <= S_WARM;
                        r_timer <= '0;
                        r_out   <= f_out(S_WARM);
                    end
                end
                S_WARM: begin
                    if (r_timer == WARM_END) begin
                        r_state <= S_UNMUTE;
                        r_timer <= '0;
                        r_out   <= f_out(S_UNMUTE);
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_UNMUTE: begin
                    if (vld) begin
                        r_state <= S_RUN;
                        r_timer <= '0;
                        r_out   <= f_out(S_RUN);
                    end
                end
                S_RUN: begin
                    r_out <= f_out(S_RUN);
                end
                S_FAULT: begin
                    if (w_flt) begin
                        r_timer <= '0;
                    end else if (r_timer == HOLD_END) begin
                        r_state <= S_IDLE;
                        r_timer <= '0;
                        r_out   <= f_out(S_IDLE);
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_LOCK: begin
                    r_out <= f_out(S_LOCK);
                end
                default: begin
                    r_state <= S_IDLE;
                    r_timer <= '0;
                    r_out   <= 4'b1100;
                end
            endcase
        end
    end

    assign sht_dwn   = r_out[3];
    assign mute      = r_out[2];
    assign amp_on    = r_out[1];
    assign locked    = r_out[0];
    assign fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_amp_pwr_seq.sv
// Bench for amp_pwr_seq: phase-level reference model checked every cycle,
// plus directed literal timing checks.
module tb_amp_pwr_seq;

    localparam int STARTUP = 16;
    localparam int HOLD    = 8;
    localparam int RMAX    = 2;

`ifdef RETRY_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       Flt_n;
    logic       seq_low;
    logic       vld;
    logic       sht_dwn;
    logic       mute;
    logic       amp_on;
    logic [3:0] fault_cnt;
    logic       locked;

    int checks;
    int errors;
    int nprint;
    int cyc;

    amp_pwr_seq #(
        .STARTUP_CYC  (STARTUP),
        .FLT_HOLD_CYC (HOLD),
        .RETRY_MAX    (RMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Flt_n     (Flt_n),
        .seq_low   (seq_low),
        .vld       (vld),
        .sht_dwn   (sht_dwn),
        .mute      (mute),
        .amp_on    (amp_on),
        .fault_cnt (fault_cnt),
        .locked    (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phases of the power sequence, not the RTL encoding.
    typedef enum int {
        P_OFF, P_WARMING, P_ARMED, P_PLAYING, P_TRIPPED, P_LOCKED
    } phase_t;

    phase_t ph;
    int     warm_left;
    int     clean;
    int     m_cnt;
    bit     pin_d1;
    bit     pin_d2;
    bit     m_valid;

    task automatic model_step();
        bit f;
        if (!rst_n) begin
            ph      = P_OFF;
            m_cnt   = 0;
            clean   = 0;
            pin_d1  = 1'b1;
            pin_d2  = 1'b1;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        f      = !pin_d2;
        pin_d2 = pin_d1;
        pin_d1 = Flt_n;
        if (f && (ph == P_WARMING || ph == P_ARMED ||
                  ph == P_PLAYING)) begin
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            ph    = (LIM && m_cnt >= RMAX) ? P_LOCKED : P_TRIPPED;
            clean = 0;
        end else begin
            case (ph)
                P_OFF: if (seq_low && !f) begin
                    ph        = P_WARMING;
                    warm_left = STARTUP;
                end
                P_WARMING: begin
                    warm_left = warm_left - 1;
                    if (warm_left == 0) ph = P_ARMED;
                end
                P_ARMED: if (vld) ph = P_PLAYING;
                P_TRIPPED: begin
                    clean = f ? 0 : clean + 1;
                    if (clean == HOLD) ph = P_OFF;
                end
                default: ;
            endcase
        end
    endtask

    initial begin
        m_valid = 1'b0;
        ph      = P_OFF;
        cyc     = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            model_step();
        end
    end

    task automatic cmp(string nm, int got, int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            if (nprint < 40) begin
                nprint = nprint + 1;
                $display("FAIL %s cyc=%0d got=%0d exp=%0d",
                         nm, cyc, got, exp);
            end
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                cmp("m_sht_dwn", int'(sht_dwn),
                    (ph == P_ARMED || ph == P_PLAYING) ? 0 : 1);
                cmp("m_mute", int'(mute), (ph == P_PLAYING) ? 0 : 1);
                cmp("m_amp_on", int'(amp_on), (ph == P_PLAYING) ? 1 : 0);
                cmp("m_locked", int'(locked), (ph == P_LOCKED) ? 1 : 0);
                cmp("m_fault_cnt", int'(fault_cnt), m_cnt);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        nprint  = 0;
        rst_n   = 1'b0;
        Flt_n   = 1'b1;
        seq_low = 1'b0;
        vld     = 1'b0;
        tick(3);
        cmp("rst_sht_dwn", int'(sht_dwn), 1);
        cmp("rst_mute", int'(mute), 1);
        cmp("rst_amp_on", int'(amp_on), 0);
        cmp("rst_fault_cnt", int'(fault_cnt), 0);
        cmp("rst_locked", int'(locked), 0);

        // Power-up: 1 cycle IDLE->WARM, 16 cycles WARM.
        rst_n   = 1'b1;
        seq_low = 1'b1;
        tick(16);
        cmp("warm_hold", int'(sht_dwn), 1);
        tick(1);
        cmp("warm_done_sht", int'(sht_dwn), 0);
        cmp("unmute_mute", int'(mute), 1);
        tick(3);
        cmp("unmute_wait", int'(mute), 1);
        vld = 1'b1;
        tick(1);
        vld = 1'b0;
        cmp("run_mute", int'(mute), 0);
        cmp("run_amp_on", int'(amp_on), 1);

        // RUN fault: one-cycle Flt_n pulse, 3-edge latency.
        Flt_n = 1'b0;
        tick(1);
        Flt_n = 1'b1;
        tick(1);
        cmp("flt_lat2", int'(sht_dwn), 0);
        tick(1);
        cmp("flt_lat3_sht", int'(sht_dwn), 1);
        cmp("flt_lat3_mute", int'(mute), 1);
        cmp("flt_cnt1", int'(fault_cnt), 1);
        // 8 clean + IDLE + 16 WARM -> release 25 edges later.
        tick(24);
        cmp("resq_hold", int'(sht_dwn), 1);
        tick(1);
        cmp("resq_sht", int'(sht_dwn), 0);

        // UNMUTE: flt and vld on the same edge.
        Flt_n = 1'b0;
        tick(1);
        Flt_n = 1'b1;
        tick(1);
        vld = 1'b1;
        tick(1);
        vld = 1'b0;
        cmp("race_mute", int'(mute), 1);
        cmp("race_sht", int'(sht_dwn), 1);
        cmp("race_cnt2", int'(fault_cnt), 2);
        cmp("race_locked", int'(locked), LIM ? 1 : 0);
`ifdef RETRY_LIMIT_EN
        tick(100);
        cmp("lock_held", int'(locked), 1);
        cmp("lock_sht", int'(sht_dwn), 1);
`else
        tick(24);
        cmp("retry_hold", int'(sht_dwn), 1);
        tick(1);
        cmp("retry_sht", int'(sht_dwn), 0);
`endif
        rst_n = 1'b0;
        tick(1);
        cmp("clr_locked", int'(locked), 0);
        cmp("clr_cnt", int'(fault_cnt), 0);
        rst_n = 1'b1;

        // Reset mid-WARM at timer=9; WARM restarts from zero.
        tick(10);
        rst_n = 1'b0;
        tick(1);
        cmp("midwarm_sht", int'(sht_dwn), 1);
        rst_n = 1'b1;
        tick(16);
        cmp("midwarm_hold", int'(sht_dwn), 1);
        tick(1);
        cmp("midwarm_rel", int'(sht_dwn), 0);

        // FAULT glitch at hold count 5 restarts the hold interval.
        Flt_n = 1'b0;
        tick(1);
        Flt_n = 1'b1;
        tick(7);
        Flt_n = 1'b0;
        tick(1);
        Flt_n = 1'b1;
        tick(26);
        cmp("glitch_hold", int'(sht_dwn), 1);
        tick(1);
        cmp("glitch_rel", int'(sht_dwn), 0);
        cmp("glitch_cnt", int'(fault_cnt), 1);

        // flt in IDLE blocks WARM but is not counted.
        rst_n   = 1'b0;
        seq_low = 1'b0;
        Flt_n   = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(6);
        seq_low = 1'b1;
        tick(5);
        cmp("idle_flt_cnt", int'(fault_cnt), 0);
        cmp("idle_flt_sht", int'(sht_dwn), 1);
        Flt_n = 1'b1;
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;

        // flt on the WARM terminal-count edge: FAULT wins.
        tick(14);
        Flt_n = 1'b0;
        tick(1);
        Flt_n = 1'b1;
        tick(2);
        cmp("term_sht", int'(sht_dwn), 1);
        cmp("term_cnt", int'(fault_cnt), 1);
        tick(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
